cic_comp_decimator: RTL and testbench

//  CIC droop-compensation FIR with decimate-by-2. Sits directly after the CIC decimator output (eno/out of that stage).
//  One time-multiplexed multiplier, TAPS-deep circular delay line, runtime-loadable coefficients.

---
 rtl/cic_comp_decimator_pkg.sv | 27 ++
 rtl/cic_comp_decimator_mac.sv | 70 +++++++
 rtl/cic_comp_decimator.sv | 130 +++++++++++++
 tb/tb_cic_comp_decimator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_decimator_pkg.sv
// Shared types and constants for the CIC droop-compensation decimating FIR.
// The default table is a mild compensator: 0.75 centre tap flanked by -0.125 taps.
package cic_comp_decimator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int acc_width(input int w, input int cw, input int taps);
    return w + cw + $clog2(taps);
  endfunction

  function automatic int default_coef(input int k, input int taps, input int cw);
    int centre;
    centre = taps / 2;
    if (k == centre) begin
      return (2 ** (cw - 2)) + (2 ** (cw - 3));
    end else if ((k == centre - 1) || (k == centre + 1)) begin
      return -(2 ** (cw - 4));
    end else begin
      return 0;
    end
  endfunction

endpackage

// File: rtl/cic_comp_decimator_mac.sv
// Single multiplier-accumulator for the compensation FIR, with round-half-up
// and saturation of the final sum back to the W-bit output format.
module cic_comp_mac
  #(parameter int W  = 16,
    parameter int CW = 16,
    parameter int AW = 35)
  (input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic                 done_i,
   input  logic signed [W-1:0]  x_i,
   input  logic signed [CW-1:0] c_i,
   output logic signed [W-1:0]  y_o,
   output logic                 vld_o);

  localparam int SW = AW - CW + 2;
  localparam logic signed [AW:0]   RND  = (AW+1)'(2 ** (CW - 2));
  localparam logic signed [SW-1:0] SMAX = SW'((2 ** (W - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (W - 1)));

  logic signed [W+CW-1:0] prod_s;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [W-1:0]    y_q;
  logic                   vld_q;

  function automatic logic signed [W-1:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW:0]   r;
    logic signed [SW-1:0] s;
    r = a + RND;
    s = r[AW:CW-1];
    if (s > SMAX) begin
      return SMAX[W-1:0];
    end else if (s < SMIN) begin
      return SMIN[W-1:0];
    end else begin
      return s[W-1:0];
    end
  endfunction

  assign prod_s = $signed({{CW{x_i[W-1]}}, x_i}) * $signed({{W{c_i[CW-1]}}, c_i});

  // Accumulator next value: sign-extended product added to the running sum.
  always_comb begin
    acc_d = acc_q + {{(AW-W-CW){prod_s[W+CW-1]}}, prod_s};
  end

  // Accumulator and rounded output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= done_i;
      if (done_i) begin
        y_q <= round_sat(acc_q);
      end
      if (clr_i) begin
        acc_q <= '0;
      end else if (en_i) begin
        acc_q <= acc_d;
      end
    end
  end

  assign y_o   = y_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/cic_comp_decimator.sv
// CIC droop-compensation FIR with decimate-by-2: circular delay line, loadable
// coefficients and one time-multiplexed MAC that runs once per pair of samples.
module cic_comp_decimator
  import cic_comp_decimator_pkg::*;
  #(parameter int W    = 16,
    parameter int CW   = 16,
    parameter int TAPS = 15)
  (input  logic                     clk,
   input  logic                     rst,
   input  logic                     eni,
   input  logic [W-1:0]             in,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic [CW-1:0]            coef_data,
   output logic                     eno,
   output logic [W-1:0]             out,
   output logic                     busy,
   output logic                     ovf);

  localparam int AW = acc_width(W, CW, TAPS);
  localparam int PW = $clog2(TAPS);

  logic signed [W-1:0]  dly_q  [TAPS];
  logic signed [CW-1:0] coef_q [TAPS];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q, tap_q;
  logic                 phase_q, ovf_q, busy_q;
  state_e               state_q, state_d;
  logic                 start_s, mac_clr_s, mac_en_s, mac_done_s;
  logic signed [W-1:0]  y_s;
  logic                 vld_s;

  assign start_s = eni & phase_q;

  // Next-state and MAC control decode.
  always_comb begin
    state_d    = state_q;
    mac_clr_s  = 1'b0;
    mac_en_s   = 1'b0;
    mac_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d   = MAC;
          mac_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        mac_en_s = 1'b1;
        if (tap_q == PW'(TAPS - 1)) begin
          state_d = OUT;
        end else begin
          state_d = MAC;
        end
      end
      OUT: begin
        mac_done_s = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Delay line, pointers, coefficient store and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tap_q    <= '0;
      phase_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= CW'(default_coef(i, TAPS, CW));
      end
    end else begin
      if (eni) begin
        dly_q[wr_ptr_q] <= in;
        wr_ptr_q        <= (wr_ptr_q == PW'(TAPS - 1)) ? '0 : wr_ptr_q + PW'(1);
        phase_q         <= ~phase_q;
      end
      // A start that lands while busy is dropped, only flagged.
      if (start_s && busy_q) begin
        ovf_q <= 1'b1;
      end
      if ((state_q == IDLE) && start_s) begin
        rd_ptr_q <= wr_ptr_q;
        tap_q    <= '0;
      end else if (state_q == MAC) begin
        rd_ptr_q <= (rd_ptr_q == '0) ? PW'(TAPS - 1) : rd_ptr_q - PW'(1);
        tap_q    <= tap_q + PW'(1);
      end
      if (coef_we && !busy_q && (coef_addr < PW'(TAPS))) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

  cic_comp_mac #(.W(W), .CW(CW), .AW(AW)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (mac_clr_s),
    .en_i   (mac_en_s),
    .done_i (mac_done_s),
    .x_i    (dly_q[rd_ptr_q]),
    .c_i    (coef_q[tap_q]),
    .y_o    (y_s),
    .vld_o  (vld_s)
  );

  assign eno  = vld_s;
  assign out  = y_s;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cic_comp_decimator.sv
// Directed bench for cic_comp_decimator (W=16, CW=16, TAPS=7): a vector table
// for impulse/DC/saturation streams plus sequences for overrun, reset and coef writes.
module tb_cic_comp_decimator;

  localparam int W    = 16;
  localparam int CW   = 16;
  localparam int TAPS = 7;
  localparam int PW   = $clog2(TAPS);

  typedef struct {
    int          grp;
    logic [15:0] x;
    bit          chk;
    logic [15:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, eni, coef_we;
  logic [W-1:0]  din;
  logic [PW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          eno, busy, ovf;
  logic [W-1:0]  dout;

  int checks   = 0;
  int failures = 0;
  int eno_cnt  = 0;
  bit tb_phase = 1'b0;

  vec_t        tbl [34];
  logic [15:0] imp_exp [4];
  logic [15:0] dc_exp  [5];
  logic [15:0] def_exp [4];
  logic [15:0] w6_exp  [4];

  always #5 clk = ~clk;

  cic_comp_decimator #(.W(W), .CW(CW), .TAPS(TAPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .eni       (eni),
    .in        (din),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .eno       (eno),
    .out       (dout),
    .busy      (busy),
    .ovf       (ovf)
  );

  always @(negedge clk) begin
    if (eno) eno_cnt <= eno_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    eni     = 1'b0;
    coef_we = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    tb_phase = 1'b0;
  endtask

  task automatic wr_coef(input logic [PW-1:0] a, input logic [CW-1:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic load_all(input int grp);
    logic [CW-1:0] d;
    for (int k = 0; k < TAPS; k++) begin
      if (grp == 1)      d = 16'(4096 * (k + 1));
      else if (grp == 3) d = 16'h7FFF;
      else               d = 16'h1000;
      wr_coef(PW'(k), d);
    end
  endtask

  // One sample in a 16-clock window; an optional c[0] write lands 3 clocks in.
  task automatic send_sample(input logic [15:0] x, input bit chk, input logic [15:0] req,
                             input string nm, input bit mid_wr);
    bit start;
    int lat;
    start    = tb_phase;
    tb_phase = ~tb_phase;
    lat      = -1;
    for (int c = 0; c < 16; c++) begin
      eni       = (c == 0);
      din       = x;
      coef_we   = mid_wr && (c == 3);
      coef_addr = '0;
      coef_data = 16'h7FFF;
      @(negedge clk);
      if (eno && (lat < 0)) lat = c + 1;
    end
    eni     = 1'b0;
    coef_we = 1'b0;
    if (start) begin
      check({nm, "_latency"}, lat, 9);
      if (chk) check({nm, "_out"}, {16'h0, dout}, {16'h0, req});
    end else begin
      check({nm, "_no_eno"}, lat, -1);
    end
  endtask

  initial begin
    int prev;
    int base;
    rst = 1'b1; eni = 1'b0; coef_we = 1'b0; din = '0; coef_addr = '0; coef_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_out",  {16'h0, dout}, 32'h0);
    check("reset_eno",  {31'h0, eno},  32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_ovf",  {31'h0, ovf},  32'h0);

    imp_exp = '{16'h1000, 16'h2000, 16'h3000, 16'h0000};
    dc_exp  = '{16'h1000, 16'h2000, 16'h3000, 16'h3800, 16'h3800};
    def_exp = '{16'h0000, 16'h2800, 16'h2000, 16'h2000};
    w6_exp  = '{16'h1000, 16'h2000, 16'h3000, 16'h3800};
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1, (i == 0) ? 16'h4000 : 16'h0000, (i % 2) == 1, imp_exp[i/2]};
    for (int i = 0; i < 10; i++)
      tbl[8+i] = '{2, 16'h4000, (i % 2) == 1, dc_exp[i/2]};
    for (int i = 0; i < 16; i++)
      tbl[18+i] = '{3, (i < 8) ? 16'h7FFF : 16'h8000, (i % 2) == 1,
                    (i < 10) ? 16'h7FFF : 16'h8000};

    prev = 0;
    for (int v = 0; v < 34; v++) begin
      if (tbl[v].grp != prev) begin
        do_reset();
        load_all(tbl[v].grp);
        prev = tbl[v].grp;
      end
      send_sample(tbl[v].x, tbl[v].chk, tbl[v].exp,
                  $sformatf("g%0d_v%0d", tbl[v].grp, v), 1'b0);
    end

    // Overrun: samples every 4 clocks with default coefficients.
    do_reset();
    base = eno_cnt;
    for (int i = 0; i < 8; i++) begin
      eni = 1'b1;
      din = 16'h4000;
      @(negedge clk);
      eni = 1'b0;
      if (i == 1) check("ovr_first_start_ovf",  {31'h0, ovf}, 32'h0);
      if (i == 3) check("ovr_second_start_ovf", {31'h0, ovf}, 32'h1);
      repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("ovr_eno_count", eno_cnt - base, 2);
    check("ovr_out", {16'h0, dout}, 32'h2000);
    check("ovr_ovf_sticky", {31'h0, ovf}, 32'h1);

    // Reset three clocks into a computation.
    tb_phase = 1'b0;
    load_all(2);
    send_sample(16'h4000, 1'b0, 16'h0, "rst_pre", 1'b0);
    eni = 1'b1;
    din = 16'h4000;
    @(negedge clk);
    eni = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_phase = 1'b0;
    check("rst_out",  {16'h0, dout}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ovf",  {31'h0, ovf},  32'h0);
    base = eno_cnt;
    repeat (20) @(negedge clk);
    check("rst_no_eno", eno_cnt - base, 0);
    for (int i = 0; i < 8; i++)
      send_sample(16'h4000, 1'b1, def_exp[i/2], $sformatf("defc_v%0d", i), 1'b0);

    // Coefficient writes while busy are dropped, while idle they take.
    do_reset();
    load_all(2);
    for (int i = 0; i < 8; i++)
      send_sample(16'h4000, 1'b1, w6_exp[i/2], $sformatf("cw_v%0d", i), i == 7);
    send_sample(16'h4000, 1'b1, 16'h3800, "cw_busy_a", 1'b0);
    send_sample(16'h4000, 1'b1, 16'h3800, "cw_busy_b", 1'b0);
    wr_coef('0, 16'h7FFF);
    send_sample(16'h4000, 1'b1, 16'h7000, "cw_idle_a", 1'b0);
    send_sample(16'h4000, 1'b1, 16'h7000, "cw_idle_b", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
